// File: rtl/mem_wb.sv
// mem_wb: MEM->WB pipeline register with the architectural HI/LO pair and the LLbit.
// Rev 1.0 - initial release.
`default_nettype none

module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic        mem_whilo,
  input  logic        mem_llbit_we,
  input  logic        mem_llbit_value,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        wb_whilo,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        llbit_o
);

  logic stall_mem;
  logic stall_wb;
  logic kill;
  logic capture;
  logic unused_stall;

  logic pend_ll_we;
  logic pend_ll_value;
  logic llbit_q;

  assign stall_mem = stall[4];
  assign stall_wb  = stall[5];
  // stall[5] without stall[4] is illegal and falls through to capture.
  assign kill      = flush | (stall_mem & ~stall_wb);
  assign capture   = ~stall_mem;
  assign unused_stall = ^stall[3:0];

  // Stage registers: flush/bubble, then capture, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wd         <= 5'd0;
      wb_wreg       <= 1'b0;
      wb_wdata      <= 32'd0;
      wb_hi         <= 32'd0;
      wb_lo         <= 32'd0;
      wb_whilo      <= 1'b0;
      pend_ll_we    <= 1'b0;
      pend_ll_value <= 1'b0;
    end else if (kill) begin
      wb_wd         <= 5'd0;
      wb_wreg       <= 1'b0;
      wb_wdata      <= 32'd0;
      wb_hi         <= 32'd0;
      wb_lo         <= 32'd0;
      wb_whilo      <= 1'b0;
      pend_ll_we    <= 1'b0;
      pend_ll_value <= 1'b0;
    end else if (capture) begin
      wb_wd         <= mem_wd;
      wb_wreg       <= mem_wreg;
      wb_wdata      <= mem_wdata;
      wb_hi         <= mem_hi;
      wb_lo         <= mem_lo;
      wb_whilo      <= mem_whilo;
      pend_ll_we    <= mem_llbit_we;
      pend_ll_value <= mem_llbit_value;
    end
  end

  // HI/LO commit whatever the stage register presents, regardless of stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_o <= 32'd0;
      lo_o <= 32'd0;
    end else if (wb_whilo) begin
      hi_o <= wb_hi;
      lo_o <= wb_lo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit_q <= 1'b0;
    end else if (flush) begin
      llbit_q <= 1'b0;
    end else if (pend_ll_we) begin
      llbit_q <= pend_ll_value;
    end
  end

  assign llbit_o = pend_ll_we ? pend_ll_value : llbit_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed scenarios plus randomized run against a cycle-level reference model.
`default_nettype none

module tb_mem_wb;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_whilo;
  logic        mem_llbit_we;
  logic        mem_llbit_value;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        wb_whilo;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        llbit_o;

  int passed = 0;
  int total  = 0;

  mem_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
    .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_whilo(wb_whilo),
    .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [167:0] outs;
  assign outs = {wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo, hi_o, lo_o, llbit_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 6'd0; flush = 1'b0;
    mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'd0;
    mem_hi = 32'd0; mem_lo = 32'd0; mem_whilo = 1'b0;
    mem_llbit_we = 1'b0; mem_llbit_value = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    stall = 6'd0; mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h1234_5678;
    mem_whilo = 1'b1; mem_hi = 32'h5; mem_lo = 32'h6;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    total++;
    if (outs !== 168'd0) $display("FAIL reset_all_zero actual=%h required=0", outs);
    else passed++;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_capture();
    do_reset();
    mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
    tick();
    total++;
    if (wb_wd !== 5'd3) $display("FAIL capture_wd actual=%0d required=3", wb_wd); else passed++;
    total++;
    if (wb_wreg !== 1'b1) $display("FAIL capture_wreg actual=%b required=1", wb_wreg); else passed++;
    total++;
    if (wb_wdata !== 32'hDEAD_BEEF) $display("FAIL capture_wdata actual=%h required=deadbeef", wb_wdata);
    else passed++;
  endtask

  task automatic test_hilo();
    do_reset();
    mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
    tick();
    total++;
    if (wb_whilo !== 1'b1 || hi_o !== 32'h0) $display("FAIL hilo_edge1 whilo=%b hi=%h required whilo=1 hi=0", wb_whilo, hi_o);
    else passed++;
    mem_whilo = 1'b0;
    tick();
    total++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) $display("FAIL hilo_edge2 hi=%h lo=%h required 1/2", hi_o, lo_o);
    else passed++;
    mem_hi = 32'hFFFF_0000; mem_lo = 32'h0000_FFFF;
    tick(); tick();
    total++;
    if (hi_o !== 32'h1 || lo_o !== 32'h2) $display("FAIL hilo_keep hi=%h lo=%h required 1/2", hi_o, lo_o);
    else passed++;
  endtask

  task automatic test_bubble_hold();
    do_reset();
    mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hA5A5_A5A5;
    tick();
    stall = 6'b110000;
    mem_wd = 5'd1; mem_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (wb_wdata !== 32'hA5A5_A5A5 || wb_wd !== 5'd7)
        $display("FAIL hold_cycle%0d wdata=%h wd=%0d required a5a5a5a5/7", i, wb_wdata, wb_wd);
      else passed++;
    end
    stall = 6'b010000;
    tick();
    total++;
    if (wb_wreg !== 1'b0 || wb_wd !== 5'd0 || wb_wdata !== 32'd0)
      $display("FAIL bubble wreg=%b wd=%0d wdata=%h required 0/0/0", wb_wreg, wb_wd, wb_wdata);
    else passed++;
    stall = 6'b100000;
    tick();
    total++;
    if (wb_wd !== 5'd1 || wb_wdata !== 32'h0BAD_0BAD)
      $display("FAIL illegal_stall_capture wd=%0d wdata=%h required 1/0bad0bad", wb_wd, wb_wdata);
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    tick(); tick();
    mem_llbit_we = 1'b0;
    tick();
    flush = 1'b1; stall = 6'b110000;
    mem_wd = 5'd4; mem_wreg = 1'b1; mem_wdata = 32'h77; mem_whilo = 1'b1;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    tick();
    total++;
    if (wb_wreg !== 1'b0 || wb_whilo !== 1'b0 || llbit_o !== 1'b0)
      $display("FAIL flush_priority wreg=%b whilo=%b llbit=%b required 0/0/0", wb_wreg, wb_whilo, llbit_o);
    else passed++;
    flush = 1'b0; stall = 6'd0;
    mem_llbit_we = 1'b0;
    tick();
    total++;
    if (llbit_o !== 1'b0) $display("FAIL flush_llbit_stays actual=%b required=0", llbit_o); else passed++;
  endtask

  task automatic test_llbit();
    do_reset();
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b1;
    tick();
    total++;
    if (llbit_o !== 1'b1) $display("FAIL ll_bypass actual=%b required=1", llbit_o); else passed++;
    mem_llbit_we = 1'b0;
    tick();
    total++;
    if (llbit_o !== 1'b1) $display("FAIL ll_committed actual=%b required=1", llbit_o); else passed++;
    mem_llbit_we = 1'b1; mem_llbit_value = 1'b0;
    tick();
    total++;
    if (llbit_o !== 1'b0) $display("FAIL sc_bypass actual=%b required=0", llbit_o); else passed++;
    mem_llbit_we = 1'b0;
    tick();
    total++;
    if (llbit_o !== 1'b0) $display("FAIL sc_committed actual=%b required=0", llbit_o); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_wd = 5'd2; mem_wreg = 1'b1; mem_wdata = 32'h99;
    mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h3;
    tick(); tick();
    stall = 6'b110000;
    tick();
    total++;
    if (wb_wreg !== 1'b1 || hi_o !== 32'h1) $display("FAIL async_pre wreg=%b hi=%h required 1/1", wb_wreg, hi_o);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (outs !== 168'd0) $display("FAIL async_reset actual=%h required=0", outs); else passed++;
    #1 rst = 1'b1;
    stall = 6'd0; mem_whilo = 1'b0; mem_wreg = 1'b0;
    tick();
    total++;
    if (wb_wreg !== 1'b0 || hi_o !== 32'd0 || wb_wdata !== 32'h99)
      $display("FAIL after_reset_release wreg=%b hi=%h wdata=%h required 0/0/99", wb_wreg, hi_o, wb_wdata);
    else passed++;
  endtask

  // Reference model: architectural state of the stage, stepped once per edge.
  task automatic test_random();
    logic [4:0]  m_wd;
    logic        m_wreg, m_whilo, m_pwe, m_pv, m_ll;
    logic [31:0] m_wdata, m_hi_s, m_lo_s, m_hi, m_lo;
    logic [167:0] exp_v;
    logic bubble;
    do_reset();
    m_wd = 0; m_wreg = 0; m_whilo = 0; m_pwe = 0; m_pv = 0; m_ll = 0;
    m_wdata = 0; m_hi_s = 0; m_lo_s = 0; m_hi = 0; m_lo = 0;
    for (int n = 0; n < 400; n++) begin
      stall = 6'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      mem_wd = 5'($urandom); mem_wreg = 1'($urandom); mem_wdata = $urandom;
      mem_hi = $urandom; mem_lo = $urandom; mem_whilo = 1'($urandom);
      mem_llbit_we = 1'($urandom); mem_llbit_value = 1'($urandom);
      tick();
      if (m_whilo) begin m_hi = m_hi_s; m_lo = m_lo_s; end
      if (flush) m_ll = 1'b0;
      else if (m_pwe) m_ll = m_pv;
      bubble = stall[4] && !stall[5];
      if (flush || bubble) begin
        m_wd = 0; m_wreg = 0; m_wdata = 0; m_hi_s = 0; m_lo_s = 0; m_whilo = 0; m_pwe = 0; m_pv = 0;
      end else if (!stall[4]) begin
        m_wd = mem_wd; m_wreg = mem_wreg; m_wdata = mem_wdata; m_hi_s = mem_hi; m_lo_s = mem_lo;
        m_whilo = mem_whilo; m_pwe = mem_llbit_we; m_pv = mem_llbit_value;
      end
      exp_v = {m_wd, m_wreg, m_wdata, m_hi_s, m_lo_s, m_whilo, m_hi, m_lo, (m_pwe ? m_pv : m_ll)};
      total++;
      if (outs !== exp_v) $display("FAIL random_cycle%0d actual=%h required=%h", n, outs, exp_v);
      else passed++;
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_capture();
    test_hilo();
    test_bubble_hold();
    test_flush();
    test_llbit();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
